// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Shared opcode, state and helper definitions for the ALU issue controller
package alu_pkg;

  localparam logic [3:0] OP_UADD = 4'd0;
  localparam logic [3:0] OP_USUB = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_LT   = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_SADD = 4'd11;
  localparam logic [3:0] OP_SSUB = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_UADD, OP_USUB, OP_AND, OP_OR, OP_NOT, OP_XOR,
      OP_SHL, OP_SHR, OP_LT, OP_EQ, OP_SADD, OP_SSUB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Only the arithmetic add/sub family produces meaningful carry/overflow.
  function automatic logic updates_flags(input logic [3:0] op);
    case (op)
      OP_UADD, OP_USUB, OP_SADD, OP_SSUB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - Instruction port and ALU operand/result bus bundle
interface alu_issue_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_operator;
  logic          alu_incoming;
  logic [DW-1:0] alu_y;
  logic          alu_carry;
  logic          alu_signov;
  logic          alu_done;

  modport master (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  alu_y, alu_carry, alu_signov, alu_done,
    output instr_ready, alu_a, alu_b, alu_operator, alu_incoming
  );

  modport slave (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output alu_y, alu_carry, alu_signov, alu_done,
    input  instr_ready, alu_a, alu_b, alu_operator, alu_incoming
  );
endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREGS x DW register file, two latched read ports, debug read, r0 hardwired to zero
module alu_regfile #(
  parameter int  DW    = 16,
  parameter int  NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data is latched at accept time and held for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data <= '0;
      rb_data <= '0;
    end else if (rd_en) begin
      ra_data <= (ra_addr == '0) ? '0 : mem[ra_addr];
      rb_data <= (rb_addr == '0) ? '0 : mem[rb_addr];
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - Issues register-file operands to the ALU, waits for done, writes back result and flags
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int  DW      = 16,
  parameter int  NREGS   = 8,
  parameter int  TIMEOUT = 15,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.master bus,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [DW-1:0]    wb_data,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err_illegal,
  output logic             err_timeout,
  input  logic [AW-1:0]    dbg_addr,
  output logic [DW-1:0]    dbg_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic          ready;
  logic          incoming;
  logic          wb_fire;
  logic          capture;
  logic          tmo_hit;
  logic          legal;
  logic          accept_legal;
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] y_q;
  logic          c_q;
  logic          v_q;
  logic [CW-1:0] cnt_q;

  assign legal        = is_legal_op(bus.instr_op);
  assign accept_legal = bus.instr_valid && ready && legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    incoming = 1'b0;
    wb_fire  = 1'b0;
    capture  = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid && legal) state_d = ST_ISSUE;
      end
      // alu_done here is a leftover level from the previous op, so it is not looked at.
      ST_ISSUE: begin
        incoming = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.alu_done) begin
          capture = 1'b1;
          state_d = ST_WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        wb_fire = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      rd_q        <= '0;
      y_q         <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      cnt_q       <= '0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_illegal <= bus.instr_valid && ready && !legal;
      err_timeout <= tmo_hit;
      if (accept_legal) begin
        op_q <= bus.instr_op;
        rd_q <= bus.instr_rd;
      end
      if (state_q == ST_ISSUE)                       cnt_q <= '0;
      else if (state_q == ST_WAIT && !bus.alu_done)  cnt_q <= cnt_q + 1'b1;
      if (capture) begin
        y_q <= bus.alu_y;
        c_q <= bus.alu_carry;
        v_q <= bus.alu_signov;
      end
      if (wb_fire && updates_flags(op_q)) begin
        flag_c <= c_q;
        flag_v <= v_q;
      end
    end
  end

  alu_regfile #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (accept_legal),
    .ra_addr  (bus.instr_rs1),
    .rb_addr  (bus.instr_rs2),
    .ra_data  (bus.alu_a),
    .rb_data  (bus.alu_b),
    .we       (wb_fire),
    .wr_addr  (rd_q),
    .wr_data  (y_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign bus.instr_ready  = ready;
  assign bus.alu_incoming = incoming;
  assign bus.alu_operator = op_q;
  assign wb_valid         = wb_fire;
  assign wb_rd            = wb_fire ? rd_q : '0;
  assign wb_data          = wb_fire ? y_q : '0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - Directed self-checking bench for alu_issue_ctrl with a scripted ALU responder
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flag_c;
  logic        flag_v;
  logic        err_illegal;
  logic        err_timeout;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks;
  int errors;

  int          inc_count, inc_cycle, wb_count, wb_cycle;
  int          tmo_count, tmo_cycle, ill_count, ill_cycle, ready_cycle, stable_err;
  logic [15:0] wb_data_seen, a_seen, b_seen;
  logic [2:0]  wb_rd_seen;
  logic [3:0]  op_seen;
  logic [15:0] rd_val;

  alu_issue_ctrl_if #(.DW(16), .AW(3)) bus ();

  alu_issue_ctrl #(.DW(16), .NREGS(8), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic read_dbg(input logic [2:0] addr, output logic [15:0] val);
    dbg_addr = addr;
    #1;
    val = dbg_data;
  endtask

  // mode 0: done one cycle after incoming; 1: never done; 2: done held high throughout
  task automatic run_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [15:0] y, input logic c,
                        input logic v, input int mode);
    inc_count = 0; inc_cycle = -1; wb_count = 0; wb_cycle = -1;
    tmo_count = 0; tmo_cycle = -1; ill_count = 0; ill_cycle = -1;
    ready_cycle = -1; stable_err = 0;
    wb_data_seen = '0; wb_rd_seen = '0; a_seen = '0; b_seen = '0; op_seen = '0;
    @(negedge clk);
    bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
    bus.instr_valid = 1'b1;
    bus.alu_y = y; bus.alu_carry = c; bus.alu_signov = v;
    bus.alu_done = (mode == 2);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      if (bus.alu_incoming) begin
        inc_count++; inc_cycle = k;
        a_seen = bus.alu_a; b_seen = bus.alu_b; op_seen = bus.alu_operator;
      end else if (inc_cycle > 0 && !bus.instr_ready &&
                   (bus.alu_a !== a_seen || bus.alu_b !== b_seen || bus.alu_operator !== op_seen)) begin
        stable_err++;
      end
      if (wb_valid) begin
        wb_count++; wb_cycle = k; wb_data_seen = wb_data; wb_rd_seen = wb_rd;
      end
      if (err_timeout) begin tmo_count++; tmo_cycle = k; end
      if (err_illegal) begin ill_count++; ill_cycle = k; end
      if (mode == 0) bus.alu_done = (inc_cycle > 0 && k == inc_cycle + 1);
      if (bus.instr_ready) begin
        ready_cycle = k;
        break;
      end
    end
    bus.alu_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.instr_ready); end
    checks++; if (bus.alu_incoming !== 1'b0) begin errors++; $display("FAIL reset_incoming: got %b expected 0", bus.alu_incoming); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if ({flag_c, flag_v, err_illegal, err_timeout} !== 4'b0) begin errors++; $display("FAIL reset_flags_errs: got %b expected 0000", {flag_c, flag_v, err_illegal, err_timeout}); end
    checks++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_operator !== 4'h0) begin errors++; $display("FAIL reset_alu_bus: got %h %h %h expected 0 0 0", bus.alu_a, bus.alu_b, bus.alu_operator); end
    read_dbg(3'd5, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL reset_reg5: got %h expected 0000", rd_val); end
  endtask

  task automatic test_sadd();
    run_op(alu_pkg::OP_OR, 3'd1, 3'd0, 3'd0, 16'h7FFF, 1'b0, 1'b0, 0);
    run_op(alu_pkg::OP_OR, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b0, 1'b0, 0);
    run_op(alu_pkg::OP_SADD, 3'd3, 3'd1, 3'd2, 16'h8000, 1'b0, 1'b1, 0);
    checks++; if (inc_count !== 1 || inc_cycle !== 1) begin errors++; $display("FAIL sadd_incoming: got count %0d cycle %0d expected 1 1", inc_count, inc_cycle); end
    checks++; if (a_seen !== 16'h7FFF || b_seen !== 16'h0001) begin errors++; $display("FAIL sadd_operands: got %h %h expected 7fff 0001", a_seen, b_seen); end
    checks++; if (op_seen !== 4'd11) begin errors++; $display("FAIL sadd_operator: got %0d expected 11", op_seen); end
    checks++; if (wb_count !== 1 || wb_cycle !== 3) begin errors++; $display("FAIL sadd_wb_cycle: got count %0d cycle %0d expected 1 3", wb_count, wb_cycle); end
    checks++; if (wb_data_seen !== 16'h8000 || wb_rd_seen !== 3'd3) begin errors++; $display("FAIL sadd_wb: got %h rd %0d expected 8000 rd 3", wb_data_seen, wb_rd_seen); end
    checks++; if (ready_cycle !== 4) begin errors++; $display("FAIL sadd_ready_cycle: got %0d expected 4", ready_cycle); end
    checks++; if (stable_err !== 0) begin errors++; $display("FAIL sadd_bus_stable: got %0d changes expected 0", stable_err); end
    checks++; if (flag_v !== 1'b1 || flag_c !== 1'b0) begin errors++; $display("FAIL sadd_flags: got c=%b v=%b expected c=0 v=1", flag_c, flag_v); end
    read_dbg(3'd3, rd_val);
    checks++; if (rd_val !== 16'h8000) begin errors++; $display("FAIL sadd_reg3: got %h expected 8000", rd_val); end
  endtask

  task automatic test_and();
    run_op(alu_pkg::OP_OR, 3'd1, 3'd0, 3'd0, 16'hF0F0, 1'b0, 1'b0, 0);
    run_op(alu_pkg::OP_OR, 3'd2, 3'd0, 3'd0, 16'hFF00, 1'b0, 1'b0, 0);
    run_op(alu_pkg::OP_AND, 3'd4, 3'd1, 3'd2, 16'hF000, 1'b1, 1'b0, 0);
    checks++; if (a_seen !== 16'hF0F0 || b_seen !== 16'hFF00) begin errors++; $display("FAIL and_operands: got %h %h expected f0f0 ff00", a_seen, b_seen); end
    checks++; if (wb_data_seen !== 16'hF000 || wb_count !== 1) begin errors++; $display("FAIL and_wb_data: got %h count %0d expected f000 1", wb_data_seen, wb_count); end
    checks++; if (flag_c !== 1'b0 || flag_v !== 1'b1) begin errors++; $display("FAIL and_flags_hold: got c=%b v=%b expected c=0 v=1", flag_c, flag_v); end
    read_dbg(3'd4, rd_val);
    checks++; if (rd_val !== 16'hF000) begin errors++; $display("FAIL and_reg4: got %h expected f000", rd_val); end
  endtask

  task automatic test_illegal();
    logic [3:0] ops [3];
    ops[0] = 4'd6; ops[1] = 4'd13; ops[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 3'd5, 3'd1, 3'd2, 16'hDEAD, 1'b1, 1'b1, 0);
      checks++; if (ill_count !== 1 || ill_cycle !== 1) begin errors++; $display("FAIL illegal_pulse op%0d: got count %0d cycle %0d expected 1 1", ops[i], ill_count, ill_cycle); end
      checks++; if (inc_count !== 0 || wb_count !== 0) begin errors++; $display("FAIL illegal_no_traffic op%0d: got inc %0d wb %0d expected 0 0", ops[i], inc_count, wb_count); end
      checks++; if (ready_cycle !== 1) begin errors++; $display("FAIL illegal_ready op%0d: got %0d expected 1", ops[i], ready_cycle); end
    end
    read_dbg(3'd5, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL illegal_reg5: got %h expected 0000", rd_val); end
  endtask

  task automatic test_timeout();
    run_op(alu_pkg::OP_UADD, 3'd6, 3'd1, 3'd2, 16'hAAAA, 1'b1, 1'b0, 1);
    checks++; if (tmo_count !== 1 || tmo_cycle !== 17) begin errors++; $display("FAIL timeout_pulse: got count %0d cycle %0d expected 1 17", tmo_count, tmo_cycle); end
    checks++; if (wb_count !== 0) begin errors++; $display("FAIL timeout_no_wb: got %0d expected 0", wb_count); end
    checks++; if (ready_cycle !== 17) begin errors++; $display("FAIL timeout_ready: got %0d expected 17", ready_cycle); end
    checks++; if (flag_c !== 1'b0 || flag_v !== 1'b1) begin errors++; $display("FAIL timeout_flags: got c=%b v=%b expected c=0 v=1", flag_c, flag_v); end
    read_dbg(3'd6, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL timeout_reg6: got %h expected 0000", rd_val); end
    run_op(alu_pkg::OP_OR, 3'd6, 3'd0, 3'd0, 16'h0055, 1'b0, 1'b0, 0);
    read_dbg(3'd6, rd_val);
    checks++; if (wb_count !== 1 || rd_val !== 16'h0055) begin errors++; $display("FAIL timeout_next_op: got wb %0d reg6 %h expected 1 0055", wb_count, rd_val); end
  endtask

  task automatic test_stale_done();
    bus.alu_done = 1'b1;
    run_op(alu_pkg::OP_XOR, 3'd7, 3'd1, 3'd2, 16'hBEEF, 1'b0, 1'b0, 2);
    checks++; if (inc_count !== 1 || wb_cycle !== 3) begin errors++; $display("FAIL stale_done_wb_cycle: got inc %0d wb cycle %0d expected 1 3", inc_count, wb_cycle); end
    checks++; if (wb_data_seen !== 16'hBEEF) begin errors++; $display("FAIL stale_done_data: got %h expected beef", wb_data_seen); end
  endtask

  task automatic test_r0_and_reset();
    run_op(alu_pkg::OP_OR, 3'd0, 3'd0, 3'd0, 16'h1234, 1'b0, 1'b0, 0);
    checks++; if (wb_count !== 1 || wb_rd_seen !== 3'd0 || wb_data_seen !== 16'h1234) begin errors++; $display("FAIL r0_wb: got count %0d rd %0d data %h expected 1 0 1234", wb_count, wb_rd_seen, wb_data_seen); end
    read_dbg(3'd0, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL r0_reads_zero: got %h expected 0000", rd_val); end
    @(negedge clk);
    bus.instr_op = alu_pkg::OP_UADD; bus.instr_rd = 3'd3; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
    bus.instr_valid = 1'b1; bus.alu_done = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.instr_ready !== 1'b1 || bus.alu_incoming !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got ready %b inc %b wb %b expected 1 0 0", bus.instr_ready, bus.alu_incoming, wb_valid); end
    checks++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_operator !== 4'h0 || flag_v !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got %h %h %h v=%b expected 0 0 0 0", bus.alu_a, bus.alu_b, bus.alu_operator, flag_v); end
    read_dbg(3'd1, rd_val);
    checks++; if (rd_val !== 16'h0) begin errors++; $display("FAIL midreset_reg1: got %h expected 0000", rd_val); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1 || wb_valid !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL midreset_release: got ready %b wb %b tmo %b expected 1 0 0", bus.instr_ready, wb_valid, err_timeout); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_rd = '0;
    bus.instr_rs1 = '0; bus.instr_rs2 = '0;
    bus.alu_y = '0; bus.alu_carry = 1'b0; bus.alu_signov = 1'b0; bus.alu_done = 1'b0;
    dbg_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_sadd();
    test_and();
    test_illegal();
    test_timeout();
    test_stale_done();
    test_r0_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
